// File: rtl/score_display_if.sv
// Score/display bundle between the game logic and the seven-segment scanner.
interface score_display_if;
  logic [1:0]  scene;
  logic [15:0] score;
  logic [15:0] best;
  logic        new_record;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (output scene, score, input best, new_record, an, seg);
  modport slave  (input scene, score, output best, new_record, an, seg);
endinterface

// File: rtl/score_display.sv
// Best-score tracker plus 4-digit multiplexed seven-segment driver with
// leading-zero blanking and live/best alternation in the game-over scene.
module score_display #(
  parameter int SCAN_DIV   = 50000,
  parameter int ALT_FRAMES = 250
) (
  input  logic            clk,
  input  logic            rst_n,
  score_display_if.slave  bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (ALT_FRAMES > 1) ? $clog2(ALT_FRAMES) : 1;
  localparam logic [1:0] SC_MENU = 2'b00;
  localparam logic [1:0] SC_OVER = 2'b10;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [FW-1:0] frame_cnt;
  logic          show_best;
  logic [15:0]   disp_val;
  logic [15:0]   src_val;
  logic [15:0]   frame_val;
  logic [1:0]    scene_q;
  logic          tick;
  logic          wrap;
  logic          go_entry;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 8'hC0;
      4'd1:    seg_enc = 8'hF9;
      4'd2:    seg_enc = 8'hA4;
      4'd3:    seg_enc = 8'hB0;
      4'd4:    seg_enc = 8'h99;
      4'd5:    seg_enc = 8'h92;
      4'd6:    seg_enc = 8'h82;
      4'd7:    seg_enc = 8'hF8;
      4'd8:    seg_enc = 8'h80;
      4'd9:    seg_enc = 8'h90;
      default: seg_enc = 8'hBF;
    endcase
  endfunction

  // A digit is blank when it and every higher digit are zero; units never blank.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd1:    lz_blank = (v[15:4] == 12'h000);
      2'd2:    lz_blank = (v[15:8] == 8'h00);
      2'd3:    lz_blank = (v[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  endfunction

  assign tick     = (presc == PW'(SCAN_DIV - 1));
  assign idx_nxt  = idx + 2'd1;
  assign wrap     = tick && (idx == 2'd3);
  assign go_entry = (bus.scene == SC_OVER) && (scene_q != SC_OVER);

  // Source select uses the registered best, so an entry edge that coincides
  // with a frame wrap still latches the pre-update value.
  always_comb begin
    src_val = bus.score;
    if (bus.scene == SC_MENU)
      src_val = bus.best;
    else if (bus.scene == SC_OVER && show_best)
      src_val = bus.best;
  end

  always_comb begin
    frame_val = wrap ? src_val : disp_val;
    case (idx_nxt)
      2'd0:    nib = frame_val[3:0];
      2'd1:    nib = frame_val[7:4];
      2'd2:    nib = frame_val[11:8];
      default: nib = frame_val[15:12];
    endcase
    blank = lz_blank(frame_val, idx_nxt);
  end

  // Scan timing and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc    <= '0;
      idx      <= 2'd3;
      disp_val <= 16'h0000;
      bus.an   <= 4'b1111;
      bus.seg  <= 8'hFF;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx     <= idx_nxt;
        bus.an  <= ~(4'b0001 << idx_nxt);
        bus.seg <= blank ? 8'hFF : seg_enc(nib);
        if (wrap)
          disp_val <= src_val;
      end
    end
  end

  // Best tracking and game-over alternation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scene_q        <= SC_MENU;
      bus.best       <= 16'h0000;
      bus.new_record <= 1'b0;
      show_best      <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      scene_q        <= bus.scene;
      bus.new_record <= 1'b0;
      if (go_entry && (bus.score > bus.best)) begin
        bus.best       <= bus.score;
        bus.new_record <= 1'b1;
      end
      if (bus.scene != SC_OVER || go_entry) begin
        show_best <= 1'b0;
        frame_cnt <= '0;
      end else if (wrap) begin
        if (frame_cnt == FW'(ALT_FRAMES - 1)) begin
          show_best <= ~show_best;
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end
endmodule
